// File: rtl/matmul_pkg.sv
// Shared types and helpers for the matrix multiplier datapath.
// State encodings, default widths and index range check.
package matmul_pkg;

  localparam int DATA_W_DEF = 32;

  localparam logic S_CAPTURE = 1'b0;
  localparam logic S_DRAIN   = 1'b1;

  function automatic logic idx_in_range(
    input int i,
    input int j,
    input int m
  );
    return (i < m) && (j < m);
  endfunction

endpackage

// File: rtl/result_buffer.sv
// M x M register file holding the product matrix C.
// One sync write port with clear-all, one comb read port.
module result_buffer
  import matmul_pkg::*;
#(
  parameter int M      = 4,
  parameter int AW     = 2,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              we,
  input  logic [AW-1:0]     wr_r,
  input  logic [AW-1:0]     wr_c,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     rd_r,
  input  logic [AW-1:0]     rd_c,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [M][M];

  // clear first so a same-edge write lands on the cleared array
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      for (int i = 0; i < M; i++) begin
        for (int j = 0; j < M; j++) begin
          mem[i][j] <= '0;
        end
      end
    end
    if (rst_n && we) begin
      mem[wr_r][wr_c] <= wdata;
    end
  end

  assign rdata = mem[rd_r][rd_c];

endmodule

// File: rtl/matrix_result_collector.sv
// Collects multiplier results into C and streams it row-major.
// Option COLLECTOR_COVERAGE_EN flags unwritten entries at drain.
module matrix_result_collector
  import matmul_pkg::*;
#(
  parameter int M      = 4,
  parameter int IDX_W  = 5,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] z_out,
  input  logic [IDX_W-1:0]  z_i,
  input  logic [IDX_W-1:0]  z_j,
  input  logic              z_stb,
  output logic              z_ack,
  input  logic              mm_done,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              busy,
  output logic              err
);

  localparam int AW = $clog2(M);
  localparam logic [AW-1:0] LAST = AW'(M - 1);

  logic              state;
  logic              pend;
  logic [AW-1:0]     r;
  logic [AW-1:0]     c;
  logic [AW-1:0]     nr;
  logic [AW-1:0]     nc;
  logic [AW-1:0]     rd_r;
  logic [AW-1:0]     rd_c;
  logic [DATA_W-1:0] rdata;
  logic              fire;
  logic              in_rng;
  logic              we;
  logic              clr;
  logic              go;
  logic              hs;
  logic              cov_hole;

  assign fire   = (state == S_CAPTURE) && z_stb && !z_ack;
  assign in_rng = idx_in_range(int'(z_i), int'(z_j), M);
  assign we     = fire && in_rng;
  assign clr    = (state == S_CAPTURE) && start;
  assign go     = (state == S_CAPTURE) && pend && !start
                  && !fire && !z_ack;
  assign hs     = (state == S_DRAIN) && m_valid && m_ready;

  // next drain position: column wraps into the next row
  always_comb begin
    nc = c + 1'b1;
    nr = r;
    if (c == LAST) begin
      nc = '0;
      nr = r + 1'b1;
    end
  end

  assign rd_r = (state == S_DRAIN) ? nr : '0;
  assign rd_c = (state == S_DRAIN) ? nc : '0;

  result_buffer #(
    .M      (M),
    .AW     (AW),
    .DATA_W (DATA_W)
  ) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .we    (we),
    .wr_r  (z_i[AW-1:0]),
    .wr_c  (z_j[AW-1:0]),
    .wdata (z_out),
    .rd_r  (rd_r),
    .rd_c  (rd_c),
    .rdata (rdata)
  );

`ifdef COLLECTOR_COVERAGE_EN
  logic [M-1:0][M-1:0] wr_bits;

  // track which entries received at least one write
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_bits <= '0;
    end else begin
      if (clr) wr_bits <= '0;
      if (we) wr_bits[z_i[AW-1:0]][z_j[AW-1:0]] <= 1'b1;
    end
  end

  assign cov_hole = ~&wr_bits;
`else
  assign cov_hole = 1'b0;
`endif

  // capture/drain FSM with write handshake and stream port
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_CAPTURE;
      pend    <= 1'b0;
      z_ack   <= 1'b0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      m_data  <= '0;
      busy    <= 1'b0;
      err     <= 1'b0;
      r       <= '0;
      c       <= '0;
    end else begin
      z_ack <= 1'b0;
      case (state)
        S_CAPTURE: begin
          if (start) begin
            err  <= 1'b0;
            pend <= 1'b0;
          end
          if (mm_done) pend <= 1'b1;
          if (fire) begin
            z_ack <= 1'b1;
            if (!in_rng) err <= 1'b1;
          end
          if (go) begin
            state   <= S_DRAIN;
            r       <= '0;
            c       <= '0;
            m_valid <= 1'b1;
            m_data  <= rdata;
            m_last  <= 1'b0;
            busy    <= 1'b1;
            if (cov_hole) err <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (hs) begin
            if (m_last) begin
              m_valid <= 1'b0;
              m_last  <= 1'b0;
              busy    <= 1'b0;
              pend    <= 1'b0;
              state   <= S_CAPTURE;
            end else begin
              r      <= nr;
              c      <= nc;
              m_data <= rdata;
              m_last <= (nr == LAST) && (nc == LAST);
            end
          end
        end
        default: state <= S_CAPTURE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_result_collector.sv
// Scoreboard bench for matrix_result_collector (M=4).
// Build with COLLECTOR_COVERAGE_EN to exercise coverage flags.
module tb_matrix_result_collector;

  localparam int M = 4;

  typedef struct {
    logic [31:0] d;
    logic        l;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] z_out;
  logic [4:0]  z_i;
  logic [4:0]  z_j;
  logic        z_stb;
  logic        z_ack;
  logic        mm_done;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
  logic        busy;
  logic        err;

  int total = 0;
  int bad = 0;
  int hs_cnt = 0;
  int ready_mode = 0;
  int pat = 0;
  logic busy_chk = 1'b0;
  logic stall_prev = 1'b0;
  logic [31:0] stall_d;
  logic stall_l;
  logic [31:0] model [M][M];
  exp_t sb[$];

  matrix_result_collector #(
    .M      (M),
    .IDX_W  (5),
    .DATA_W (32)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .z_out   (z_out),
    .z_i     (z_i),
    .z_j     (z_j),
    .z_stb   (z_stb),
    .z_ack   (z_ack),
    .mm_done (mm_done),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_last  (m_last),
    .busy    (busy),
    .err     (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h want=%h", n, a, e);
    end
  endtask

  task automatic fail_to(input string n);
    total++;
    bad++;
    $display("FAIL %s timeout", n);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < M; i++)
      for (int j = 0; j < M; j++)
        model[i][j] = '0;
  endtask

  task automatic push_stream();
    exp_t e;
    for (int i = 0; i < M; i++)
      for (int j = 0; j < M; j++) begin
        e.d = model[i][j];
        e.l = (i == M - 1) && (j == M - 1);
        sb.push_back(e);
      end
  endtask

  task automatic write(input int i, input int j,
                       input logic [31:0] d);
    bit ok = 0;
    z_i = 5'(i);
    z_j = 5'(j);
    z_out = d;
    z_stb = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (z_ack) begin
        ok = 1;
        break;
      end
    end
    z_stb = 1'b0;
    if (!ok) fail_to("write_ack");
    if (i < M && j < M) model[i][j] = d;
  endtask

  task automatic wait_busy(input logic v, input int lim,
                           input string n);
    bit ok = 0;
    for (int k = 0; k < lim; k++) begin
      if (busy === v) begin
        ok = 1;
        break;
      end
      tick();
    end
    if (!ok) fail_to(n);
  endtask

  task automatic drain_all();
    int base;
    push_stream();
    base = hs_cnt;
    mm_done = 1'b1;
    tick();
    mm_done = 1'b0;
    wait_busy(1'b1, 10, "busy_rise");
    wait_busy(1'b0, 300, "busy_fall");
    tick();
    chk("hs_count", 32'(hs_cnt - base), 32'(M * M));
    chk("sb_left", 32'(sb.size()), 32'd0);
  endtask

  // consumer ready: always 1, or the 1,0,0 stall pattern
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_ready = (ready_mode == 0) ? 1'b1 : (pat % 3 == 0);
      pat++;
    end
  end

  // monitor: pop the scoreboard on every stream handshake
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (busy_chk) begin
        chk("busy_after_last", 32'(busy), 32'd0);
        busy_chk = 1'b0;
      end
      if (rst_n && stall_prev && m_valid) begin
        chk("stall_data", m_data, stall_d);
        chk("stall_last", 32'(m_last), 32'(stall_l));
      end
      stall_prev = rst_n && m_valid && !m_ready;
      stall_d = m_data;
      stall_l = m_last;
      if (rst_n && m_valid && m_ready) begin
        hs_cnt++;
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_beat got=%h", m_data);
        end else begin
          e = sb.pop_front();
          chk("stream_data", m_data, e.d);
          chk("stream_last", 32'(m_last), 32'(e.l));
          if (e.l) busy_chk = 1'b1;
        end
      end
    end
  end

  initial begin
    logic [31:0] v [5];
    logic cov_err;
    int base;
    bit ok;
`ifdef COLLECTOR_COVERAGE_EN
    cov_err = 1'b1;
`else
    cov_err = 1'b0;
`endif
    rst_n = 1'b0;
    start = 1'b0;
    z_out = '0;
    z_i = '0;
    z_j = '0;
    z_stb = 1'b0;
    mm_done = 1'b0;
    clear_model();
    tick();
    tick();
    chk("rst_z_ack", 32'(z_ack), 32'd0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_last", 32'(m_last), 32'd0);
    chk("rst_m_data", m_data, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;

    // overwrite of (0,0) plus a full matrix
    write(0, 0, 32'h3F80_0000);
    write(0, 0, 32'h4000_0000);
    for (int i = 0; i < M; i++)
      for (int j = 0; j < M; j++)
        if (i != 0 || j != 0) write(i, j, 32'(i * 4 + j));
    drain_all();
    chk("t1_err", 32'(err), 32'd0);

    // z_stb held 5 cycles: ack on alternate cycles
    v[0] = 32'hA0; v[1] = 32'hA1; v[2] = 32'hA2;
    v[3] = 32'hA3; v[4] = 32'hA4;
    z_i = 5'd3;
    z_j = 5'd3;
    z_stb = 1'b1;
    for (int k = 0; k < 5; k++) begin
      z_out = v[k];
      tick();
      chk("hold_ack", 32'(z_ack), (k % 2 == 0) ? 32'd1 : 32'd0);
    end
    z_stb = 1'b0;
    model[3][3] = 32'hA4;
    tick();

    // drain with a stalling consumer
    ready_mode = 1;
    drain_all();
    ready_mode = 0;

    // out-of-range row index
    chk("t4_err_pre", 32'(err), 32'd0);
    z_i = 5'd5;
    z_j = 5'd0;
    z_out = 32'hDEAD_BEEF;
    z_stb = 1'b1;
    tick();
    z_stb = 1'b0;
    chk("oor_ack", 32'(z_ack), 32'd1);
    chk("oor_err", 32'(err), 32'd1);
    tick();
    drain_all();
    chk("oor_err_kept", 32'(err), 32'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    clear_model();
    chk("start_err", 32'(err), 32'd0);

    // mm_done on the same edge as a write, z_stb during drain
    z_i = 5'd0;
    z_j = 5'd2;
    z_out = 32'h55;
    z_stb = 1'b1;
    mm_done = 1'b1;
    model[0][2] = 32'h55;
    push_stream();
    base = hs_cnt;
    tick();
    mm_done = 1'b0;
    z_stb = 1'b0;
    chk("t5_ack", 32'(z_ack), 32'd1);
    wait_busy(1'b1, 10, "t5_busy_rise");
    z_i = 5'd2;
    z_j = 5'd2;
    z_out = 32'h77;
    z_stb = 1'b1;
    for (int k = 0; k < 300; k++) begin
      tick();
      if (!busy) break;
      chk("no_ack_in_drain", 32'(z_ack), 32'd0);
    end
    ok = 0;
    for (int k = 0; k < 10; k++) begin
      if (z_ack) begin
        ok = 1;
        break;
      end
      tick();
    end
    if (!ok) fail_to("t5_late_ack");
    z_stb = 1'b0;
    model[2][2] = 32'h77;
    tick();
    chk("t5_hs_count", 32'(hs_cnt - base), 32'(M * M));
    chk("t5_sb_left", 32'(sb.size()), 32'd0);

    // reset after three stream handshakes
    push_stream();
    base = hs_cnt;
    mm_done = 1'b1;
    tick();
    mm_done = 1'b0;
    ok = 0;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (hs_cnt - base >= 3) begin
        ok = 1;
        break;
      end
    end
    if (!ok) fail_to("t6_three_beats");
    rst_n = 1'b0;
    tick();
    chk("t6_m_valid", 32'(m_valid), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_z_ack", 32'(z_ack), 32'd0);
    chk("t6_m_last", 32'(m_last), 32'd0);
    sb.delete();
    clear_model();
    rst_n = 1'b1;
    tick();

    // 15 of 16 entries written; (2,3) never written
    for (int i = 0; i < M; i++)
      for (int j = 0; j < M; j++)
        if (i != 2 || j != 3) write(i, j, 32'(32'h100 + i * 4 + j));
    drain_all();
    chk("t7_err", 32'(err), 32'(cov_err));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "global timeout");
  end

endmodule
